// File: rtl/lb_pkg.sv
// Shared definitions for the lattice-Boltzmann initialisation sequencer.
// Contents: Q2.25 format constants, equilibrium weights, FSM state encoding,
// and the saturating narrow-to-Q2.25 helper used by the datapath.
package lb_pkg;

    localparam int QW   = 27;
    localparam int FRAC = 25;

    localparam logic signed [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic signed [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

    // Equilibrium weights in Q2.25: 4/9, 1/9, 1/36.
    localparam logic signed [QW-1:0] W0 = 27'sd14913081;
    localparam logic signed [QW-1:0] W1 = 27'sd3728270;
    localparam logic signed [QW-1:0] W2 = 27'sd932068;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_WRITE = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } lb_state_e;

    // Clamp a wide signed value into the Q2.25 range.
    function automatic logic signed [QW-1:0] sat_q(input logic signed [63:0] v);
        logic signed [QW-1:0] r;
        if (v > 64'sd67108863) begin
            r = Q_MAX;
        end else if (v < -64'sd67108864) begin
            r = Q_MIN;
        end else begin
            r = v[QW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lb_init_seq_fxmul.sv
// Combinational 27x27 signed Q2.25 multiplier with saturation.
// Ports: a_i, b_i  Q2.25 operands; p_o  saturated (a*b)>>>25 (floor).
module lb_fxmul
    import lb_pkg::*;
(
    input  logic signed [QW-1:0] a_i,
    input  logic signed [QW-1:0] b_i,
    output logic signed [QW-1:0] p_o
);

    logic signed [2*QW-1:0] prod_s;
    logic signed [63:0]     shifted_s;

    assign prod_s    = a_i * b_i;
    // Arithmetic shift on a sign-extended copy gives truncation toward -inf.
    assign shifted_s = $signed({{(64-2*QW){prod_s[2*QW-1]}}, prod_s}) >>> FRAC;
    assign p_o       = sat_q(shifted_s);

endmodule

// File: rtl/lb_init_seq.sv
// Lattice initialisation sequencer: computes D2Q9 equilibrium populations for
// an inlet velocity u0 on one shared multiplier, streams them to NCELLS
// addresses, then hands off to the collide/stream FSM and waits for it.
// Ports: clk, rst (async active-low), go/u0 start request and velocity,
// n*_init_data/ux/uy data, write_address_init/init_we write strobe,
// start_init/init_finish handshake, busy status and one-cycle done pulse.
module lb_init_seq
    import lb_pkg::*;
#(
    parameter int NCELLS = 16384,
    parameter int AW     = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic signed [QW-1:0] u0,
    output logic signed [QW-1:0] n0_init_data,
    output logic signed [QW-1:0] nN_init_data,
    output logic signed [QW-1:0] nS_init_data,
    output logic signed [QW-1:0] nW_init_data,
    output logic signed [QW-1:0] nE_init_data,
    output logic signed [QW-1:0] nNW_init_data,
    output logic signed [QW-1:0] nNE_init_data,
    output logic signed [QW-1:0] nSW_init_data,
    output logic signed [QW-1:0] nSE_init_data,
    output logic signed [QW-1:0] ux_init_data,
    output logic signed [QW-1:0] uy_init_data,
    output logic [AW-1:0]        write_address_init,
    output logic                 init_we,
    output logic                 start_init,
    input  logic                 init_finish,
    output logic                 busy,
    output logic                 done
);

    localparam logic [AW-1:0]      LAST_ADDR = AW'(NCELLS - 1);
    localparam logic [AW-1:0]      ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [2:0]         CALC_LAST = 3'd5;
    localparam logic signed [31:0] ONE_W     = 32'sd33554432;

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n_s;

    lb_state_e            state_q, state_d;
    logic [2:0]           calc_cnt_q, calc_cnt_d;
    logic [AW-1:0]        cell_cnt_q, cell_cnt_d;
    logic signed [QW-1:0] u0_q, u0_d, usq_q, usq_d;
    logic signed [QW-1:0] stage_q [0:4];
    logic signed [QW-1:0] stage_d [0:4];
    logic signed [QW-1:0] n0_q, n0_d, nns_q, nns_d, ne_q, ne_d, nw_q, nw_d;
    logic signed [QW-1:0] ndp_q, ndp_d, ndm_q, ndm_d, ux_q, ux_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 we_q, we_d, start_q, start_d, busy_q, busy_d, done_q, done_d;

    logic signed [31:0]   u_w_s, usq_w_s;
    logic signed [QW-1:0] coef_a_s, coef_p_s, coef_m_s;
    logic signed [QW-1:0] mul_a_s, mul_b_s, mul_p_s;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_s    = rst_sync_q[1];

    // Reset synchroniser: asserts immediately, releases two clocks later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    lb_fxmul u_fxmul (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (mul_p_s)
    );

    // Polynomial terms a, p, m of the equilibrium from the latched u0 and u0^2.
    always_comb begin
        u_w_s    = 32'(u0_q);
        usq_w_s  = 32'(usq_q);
        coef_a_s = sat_q(64'(ONE_W - ((32'sd3 * usq_w_s) >>> 1)));
        coef_p_s = sat_q(64'(ONE_W + (32'sd3 * u_w_s) + (32'sd3 * usq_w_s)));
        coef_m_s = sat_q(64'(ONE_W - (32'sd3 * u_w_s) + (32'sd3 * usq_w_s)));
    end

    // Multiplier operand select. In IDLE it squares the live u0 so that u0^2
    // is captured on the accept edge, leaving six CALC cycles for six products.
    always_comb begin
        mul_a_s = u0;
        mul_b_s = u0;
        if (state_q == ST_CALC) begin
            case (calc_cnt_q)
                3'd0:    begin mul_a_s = W0; mul_b_s = coef_a_s; end
                3'd1:    begin mul_a_s = W1; mul_b_s = coef_a_s; end
                3'd2:    begin mul_a_s = W1; mul_b_s = coef_p_s; end
                3'd3:    begin mul_a_s = W1; mul_b_s = coef_m_s; end
                3'd4:    begin mul_a_s = W2; mul_b_s = coef_p_s; end
                3'd5:    begin mul_a_s = W2; mul_b_s = coef_m_s; end
                default: begin mul_a_s = {QW{1'b0}}; mul_b_s = {QW{1'b0}}; end
            endcase
        end else begin
            mul_a_s = u0;
            mul_b_s = u0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        calc_cnt_d = calc_cnt_q;
        cell_cnt_d = cell_cnt_q;
        u0_d       = u0_q;
        usq_d      = usq_q;
        stage_d    = stage_q;
        n0_d       = n0_q;
        nns_d      = nns_q;
        ne_d       = ne_q;
        nw_d       = nw_q;
        ndp_d      = ndp_q;
        ndm_d      = ndm_q;
        ux_d       = ux_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_CALC;
                    calc_cnt_d = 3'd0;
                    u0_d       = u0;
                    usq_d      = mul_p_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (calc_cnt_q == CALC_LAST) begin
                    // Publish all results together so outputs never show a mix
                    // of old and new populations.
                    n0_d       = stage_q[0];
                    nns_d      = stage_q[1];
                    ne_d       = stage_q[2];
                    nw_d       = stage_q[3];
                    ndp_d      = stage_q[4];
                    ndm_d      = mul_p_s;
                    ux_d       = u0_q;
                    cell_cnt_d = {AW{1'b0}};
                    state_d    = ST_WRITE;
                end else begin
                    stage_d[calc_cnt_q] = mul_p_s;
                    calc_cnt_d          = calc_cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                we_d   = 1'b1;
                addr_d = cell_cnt_q;
                if (cell_cnt_q == LAST_ADDR) begin
                    state_d = ST_START;
                end else begin
                    cell_cnt_d = cell_cnt_q + ADDR_ONE;
                end
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (init_finish) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, operand latches, staging and registered outputs.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            calc_cnt_q <= 3'd0;
            cell_cnt_q <= {AW{1'b0}};
            u0_q       <= {QW{1'b0}};
            usq_q      <= {QW{1'b0}};
            for (int i = 0; i < 5; i++) begin
                stage_q[i] <= {QW{1'b0}};
            end
            n0_q       <= {QW{1'b0}};
            nns_q      <= {QW{1'b0}};
            ne_q       <= {QW{1'b0}};
            nw_q       <= {QW{1'b0}};
            ndp_q      <= {QW{1'b0}};
            ndm_q      <= {QW{1'b0}};
            ux_q       <= {QW{1'b0}};
            addr_q     <= {AW{1'b0}};
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            calc_cnt_q <= calc_cnt_d;
            cell_cnt_q <= cell_cnt_d;
            u0_q       <= u0_d;
            usq_q      <= usq_d;
            stage_q    <= stage_d;
            n0_q       <= n0_d;
            nns_q      <= nns_d;
            ne_q       <= ne_d;
            nw_q       <= nw_d;
            ndp_q      <= ndp_d;
            ndm_q      <= ndm_d;
            ux_q       <= ux_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign n0_init_data       = n0_q;
    assign nN_init_data       = nns_q;
    assign nS_init_data       = nns_q;
    assign nE_init_data       = ne_q;
    assign nW_init_data       = nw_q;
    assign nNE_init_data      = ndp_q;
    assign nSE_init_data      = ndp_q;
    assign nNW_init_data      = ndm_q;
    assign nSW_init_data      = ndm_q;
    assign ux_init_data       = ux_q;
    assign uy_init_data       = {QW{1'b0}};
    assign write_address_init = addr_q;
    assign init_we            = we_q;
    assign start_init         = start_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: doc/lb_init_seq.md
LB_INIT_SEQ -- requirements
Module: lb_init_seq

Interface
REQ-001 Parameter NCELLS, default 16384: lattice cells to initialise.
REQ-002 Parameter AW, default 14: width of write_address_init.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 go  in  1  start request, sampled only in IDLE.
REQ-006 u0  in  27  signed Q2.25 inlet x-velocity; sampled on go acceptance.
REQ-007 n0/nN/nS/nW/nE/nNW/nNE/nSW/nSE_init_data  out  27 each  signed Q2.25 equilibrium populations.
REQ-008 ux_init_data, uy_init_data  out  27 each  signed Q2.25 velocities.
REQ-009 write_address_init  out  AW  cell address for current write.
REQ-010 init_we  out  1  init data and address valid this cycle.
REQ-011 start_init  out  1  level request to collide_stream_fsm init phase.
REQ-012 init_finish  in  1  completion from collide_stream_fsm.
REQ-013 busy  out  1  high in any state but IDLE.
REQ-014 done  out  1  one-cycle pulse when sequence completes.

Function
REQ-015 States: IDLE, CALC, WRITE, START, WAIT, DONE.
REQ-016 IDLE->CALC when go=1: latch u0, zero the 6-cycle calc counter.
REQ-017 go in any state other than IDLE is ignored, with no queuing.
REQ-018 CALC shall last exactly 6 cycles on one shared Q2.25 multiplier and then enter WRITE.
REQ-019 Products: (a*b)>>>25, arithmetic shift, truncation toward -inf.
REQ-020 usq = u0*u0; a = 1 - 1.5*usq; p = 1 + 3*u0 + 3*usq; m = 1 - 3*u0 + 3*usq.
REQ-021 Populations: n0 = W0*a; nN = nS = W1*a; nE = W1*p; nW = W1*m; nNE = nSE = W2*p; nNW = nSW = W2*m.
REQ-022 Velocities: ux_init_data = u0; uy_init_data = 0.
REQ-023 Weights: W0 = 14913081 (4/9), W1 = 3728270 (1/9), W2 = 932068 (1/36).
REQ-024 Each result shall saturate to [-2^26, 2^26-1].
REQ-025 WRITE: init_we=1 for exactly NCELLS consecutive cycles; address 0..NCELLS-1, +1 per cycle.
REQ-026 Data outputs shall stay constant throughout WRITE.
REQ-027 After address NCELLS-1 the counter shall not wrap; next state START.
REQ-028 START: assert start_init, enter WAIT next cycle.
REQ-029 WAIT: hold start_init=1 until init_finish=1, then deassert start_init and enter DONE.
REQ-030 init_finish outside WAIT is ignored.
REQ-031 DONE: done=1 for one cycle, then return to IDLE.
REQ-032 Latency: first init_we exactly 7 cycles after the go-accept edge.
REQ-033 Data outputs shall retain their last values in IDLE until the next CALC completes.

Reset
REQ-034 rst=0 asynchronously forces IDLE and clears counters and all outputs to 0 (data, address, init_we, start_init, busy, done).
REQ-035 rst mid-WRITE or mid-WAIT aborts with no further writes; a new go is required after release.
REQ-036 Reset release synchronised to clk inside the block.

Structure
REQ-037 Package lb_pkg: Q2.25 width (27), FRAC=25, weights W0/W1/W2, state encoding.
REQ-038 One sub-module lb_fxmul: 27x27 signed Q2.25 multiply with saturation, shared by CALC.
REQ-039 Target size 120-400 RTL lines; no RAM inside the block.

Verification
REQ-040 u0=0, go: n0=14913081; nN/nS/nE/nW=3728270; diagonals=932068; ux=uy=0; NCELLS writes, addresses 0..16383.
REQ-041 u0=3355443 (0.1): nE > nW; nNE = nSE; nNW = nSW; each equals the bit-exact value from a model of REQ-019..REQ-024.
REQ-042 NCELLS=4, go: init_we for exactly 4 cycles starting 7 cycles after go; start_init held until init_finish driven 20 cycles later; done 1 cycle after that.
REQ-043 go pulsed during WRITE and WAIT, and init_finish pulsed during WRITE: both have no effect; write count and address sequence unchanged.
REQ-044 rst=0 at address 100 of WRITE: all outputs 0 immediately, IDLE; after release and go, writes restart from address 0.
REQ-045 u0 = 2^26-1: outputs saturated with no wrap; sequence completes normally.
